msg_asm: RTL
============

MSG_ASM -- requirements
Module: msg_asm

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8: width of one UART word.
REQ-002 SHALL have parameter WORDS_PER_PACKET, default 4: words per assembled message.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000: inter-word gap that abandons a partial message; 0 disables the timeout.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port data_in, input, WORD_SIZE: received word from the UART receiver.
REQ-007 SHALL have port data_in_valid, input, 1: one-cycle strobe marking data_in as valid.
REQ-008 SHALL have port fifo_ready, input, 1: high when the FIFO can accept a write.
REQ-009 SHALL have port data_out, output, WORD_SIZE*WORDS_PER_PACKET: assembled message.
REQ-010 SHALL have port data_out_req, output, 1: one-cycle FIFO write strobe.
REQ-011 SHALL have port overrun, output, 1: one-cycle pulse when a word is dropped.
REQ-012 SHALL have port timeout, output, 1: one-cycle pulse when a partial message is discarded.

Function
REQ-013 SHALL implement states SM_RX (collecting), SM_WAIT (message complete, FIFO not yet ready) and SM_WR (write strobe).
REQ-014 SHALL, in SM_RX on data_in_valid, write data_in to slot ctr (bits [(ctr+1)*WORD_SIZE-1 : ctr*WORD_SIZE]) of data_out at the next edge, and increment ctr.
REQ-015 SHALL therefore place the first word received in the least-significant slot.
REQ-016 SHALL, when the accepted word is slot WORDS_PER_PACKET-1, enter SM_WAIT at the next edge.
REQ-017 SHALL, in SM_WAIT, enter SM_WR at the next edge when fifo_ready is high; otherwise it SHALL remain in SM_WAIT indefinitely.
REQ-018 SHALL assert data_out_req only while in SM_WR, which lasts exactly one cycle, then return to SM_RX with ctr = 0.
REQ-019 SHALL hold data_out stable from entry to SM_WAIT until the first word of the next message is written.
REQ-020 SHALL drop any data_in_valid arriving in SM_WAIT or SM_WR, leaving data_out and ctr unchanged, and pulse overrun in the following cycle.
REQ-021 SHALL, in SM_RX with 0 < ctr < WORDS_PER_PACKET, count consecutive cycles without data_in_valid; any accepted word clears the count.
REQ-022 SHALL, when the count reaches TIMEOUT_CYCLES, set ctr to 0 and pulse timeout in the next cycle; data_out contents are don't-care.
REQ-023 SHALL give priority to data_in_valid when a word arrives in the same cycle the count reaches TIMEOUT_CYCLES: the word is accepted and no timeout occurs.
REQ-024 SHALL size ctr as $clog2(WORDS_PER_PACKET+1) bits and the gap counter as $clog2(TIMEOUT_CYCLES+1) bits, and neither counter shall wrap.
REQ-025 SHALL behave correctly with WORDS_PER_PACKET = 1: every accepted word goes directly to SM_WAIT.
REQ-026 SHALL add minimum latency of 2 cycles from the last word's strobe to data_out_req when fifo_ready is held high.

Reset
REQ-027 SHALL on reset force state SM_RX and ctr = 0, clear the gap counter and data_out to 0, and drive data_out_req, overrun and timeout low.
REQ-028 SHALL, when reset is asserted mid-message or in SM_WAIT, discard the partial or complete message with no write strobe.

Structure
REQ-029 SHALL take the state enum and default parameter values from shared package msg_pkg, also used by msg_disasm.
REQ-030 SHALL place the gap counter and timeout compare in sub-module gap_timer (inputs: clear, enable; output: expired).

Verification
REQ-031 SHALL cover: WORD_SIZE 8, WORDS_PER_PACKET 4, words 0x11,0x22,0x33,0x44 with fifo_ready=1 -> one data_out_req, data_out=0x44332211, 2 cycles after the last strobe.
REQ-032 SHALL cover: fifo_ready=0 for 50 cycles after a full message, then 1 -> data_out_req exactly once, 1 cycle after fifo_ready rises, data_out unchanged throughout.
REQ-033 SHALL cover: 0xAA sent while in SM_WAIT -> overrun pulses once, and the written message does not contain 0xAA.
REQ-034 SHALL cover: TIMEOUT_CYCLES 10, two words then 10 idle cycles -> timeout pulse, and the next 4 words 0x01..0x04 give data_out 0x04030201.
REQ-035 SHALL cover: reset asserted asynchronously after 3 words -> outputs 0 immediately, and a following full message is assembled correctly.
REQ-036 SHALL cover: msg_disasm looped back to msg_asm through a FIFO model with 100 random messages -> every message is reproduced bit-exact, in order.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared definitions for the UART message assembler and disassembler:
// controller state encoding and default parameter values.
package msg_pkg;

  localparam int DEF_WORD_SIZE        = 8;
  localparam int DEF_WORDS_PER_PACKET = 4;
  localparam int DEF_TIMEOUT_CYCLES   = 1000;

  typedef enum logic [1:0] {
    SM_RX   = 2'd0,
    SM_WAIT = 2'd1,
    SM_WR   = 2'd2
  } sm_e;

endpackage

// File: rtl/msg_asm_gap_timer.sv
// Counts consecutive idle cycles inside a partial message and flags the
// cycle in which that count reaches TIMEOUT_CYCLES (0 disables it).
module gap_timer
  import msg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The idle cycle that brings the count up to the limit is the expiring one.
  assign expired = (TIMEOUT_CYCLES != 0) && enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/msg_asm.sv
// Assembles WORDS_PER_PACKET UART words (first word in the LSB slot) into one
// message and writes it to a FIFO, with overrun and inter-word timeout pulses.
module msg_asm
  import msg_pkg::*;
#(
  parameter int WORD_SIZE        = DEF_WORD_SIZE,
  parameter int WORDS_PER_PACKET = DEF_WORDS_PER_PACKET,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [WORD_SIZE-1:0]                  data_in,
  input  logic                                  data_in_valid,
  input  logic                                  fifo_ready,
  output logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_out,
  output logic                                  data_out_req,
  output logic                                  overrun,
  output logic                                  timeout
);

  localparam int CTR_W = $clog2(WORDS_PER_PACKET + 1);
  localparam int MSG_W = WORD_SIZE * WORDS_PER_PACKET;
  localparam logic [CTR_W-1:0] LAST_SLOT = CTR_W'(WORDS_PER_PACKET - 1);

  sm_e              state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [MSG_W-1:0] data_q, data_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;

  logic gap_en, gap_clr, gap_exp;

  // Gap counting only runs while a partial message is waiting for its next word.
  assign gap_en  = (state_q == SM_RX) && (ctr_q != '0) && !data_in_valid;
  assign gap_clr = !gap_en;

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (gap_clr),
    .enable (gap_en),
    .expired(gap_exp)
  );

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    data_d    = data_q;
    overrun_d = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      SM_RX: begin
        if (data_in_valid) begin
          for (int s = 0; s < WORDS_PER_PACKET; s++) begin
            if (ctr_q == CTR_W'(s)) begin
              data_d[s*WORD_SIZE +: WORD_SIZE] = data_in;
            end
          end
          ctr_d = ctr_q + CTR_W'(1);
          if (ctr_q == LAST_SLOT) begin
            state_d = SM_WAIT;
          end
        end else if (gap_exp) begin
          ctr_d     = '0;
          timeout_d = 1'b1;
        end
      end
      SM_WAIT: begin
        overrun_d = data_in_valid;
        if (fifo_ready) begin
          state_d = SM_WR;
        end
      end
      SM_WR: begin
        overrun_d = data_in_valid;
        state_d   = SM_RX;
        ctr_d     = '0;
      end
      default: begin
        state_d = SM_RX;
        ctr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SM_RX;
      ctr_q     <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign data_out     = data_q;
  assign data_out_req = (state_q == SM_WR);
  assign overrun      = overrun_q;
  assign timeout      = timeout_q;

endmodule
